dv_checkpoint_monitor: RTL and testbench



---
 rtl/dv_checkpoint_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_dv_checkpoint_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dv_checkpoint_monitor.sv
// rtl/dv_checkpoint_monitor.sv - ordered firmware checkpoint sequencer with glitch filter and sticky verdict
//
// Purpose: watches a firmware-driven checkbits bus for the ordered codes
// BASE_CODE, BASE_CODE+1, ... BASE_CODE+NUM_STAGES-1. Values only count once
// they have been stable for STABLE_CYC sampling edges. The block reports pass,
// fail (FAIL_CODE or out-of-order code) or timeout, plus the number of stages
// reached and the cycles spent since arming.
//
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     synchronous active-high reset
//   start_i      one-cycle pulse, arms or re-arms the monitor from any state
//   checkbits_i  observed checkpoint bus (CHECK_W bits)
//   busy_o       high while armed
//   pass_o       sticky, all stages seen in order
//   fail_o       sticky, FAIL_CODE or out-of-order code seen
//   timeout_o    sticky, timeout window elapsed
//   err_code_o   0 none, 1 FAIL_CODE, 2 out-of-order, 3 timeout
//   stage_o      stages completed (0..NUM_STAGES)
//   cycles_o     cycles since arming, frozen at the terminal event
//
// Optional feature macro: DV_CHKMON_STAGE_TIMEOUT_EN
//   defined   -> timeout window restarts at every stage advance
//   undefined -> single global timeout window measured from arming

module dv_checkpoint_monitor #(
  parameter int                 CHECK_W     = 16,
  parameter int                 NUM_STAGES  = 2,
  parameter logic [CHECK_W-1:0] BASE_CODE   = 16'hAB60,
  parameter logic [CHECK_W-1:0] FAIL_CODE   = 16'hAB6F,
  parameter int                 STABLE_CYC  = 4,
  parameter int                 TIMEOUT_CYC = 1000000,
  parameter int                 CNT_W       = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [CHECK_W-1:0] checkbits_i,
  output logic               busy_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic               timeout_o,
  output logic [1:0]         err_code_o,
  output logic [3:0]         stage_o,
  output logic [CNT_W-1:0]   cycles_o
);

  localparam int               RUN_W      = $clog2(STABLE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]       LAST_STAGE = 5'(NUM_STAGES);

  // A FAIL_CODE equal to one of the stage codes would make the verdict ambiguous.
  function automatic logic fail_collides();
    logic [CHECK_W-1:0] code;
    fail_collides = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      code = BASE_CODE + CHECK_W'(k);
      if (code == FAIL_CODE) fail_collides = 1'b1;
    end
  endfunction

  if (fail_collides()) begin : g_code_collision
    $error("dv_checkpoint_monitor: FAIL_CODE collides with a stage code");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t             state_q;
  logic [CHECK_W-1:0] cand_q;
  logic [RUN_W-1:0]   run_q;
  logic [RUN_W-1:0]   run_d;
  logic [CHECK_W-1:0] acc_q;
  logic               acc_vld_q;
  logic [3:0]         stage_q;
  logic [3:0]         stage_d;
  logic [CNT_W-1:0]   cycles_q;
  logic               busy_q;
  logic               pass_q;
  logic               fail_q;
  logic               timeout_q;
  logic [1:0]         err_q;
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
  logic [CNT_W-1:0]   tmr_q;
`endif

  logic               hit;
  logic               new_val;
  logic [CHECK_W-1:0] exp_code;
  logic [CHECK_W-1:0] rel_code;
  logic               adv;
  logic               last;
  logic               is_fail;
  logic               is_ooo;
  logic               tmo;

  always_comb begin
    // Run length including the sample taken on this edge.
    run_d    = (checkbits_i == cand_q) ? ((run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1))
                                       : RUN_W'(1);
    hit      = (run_d == RUN_MAX);
    // A saturated run keeps hitting; only a value different from the last
    // accepted one produces a new event.
    new_val  = hit && (!acc_vld_q || (checkbits_i != acc_q));
    exp_code = BASE_CODE + CHECK_W'(stage_q);
    rel_code = checkbits_i - BASE_CODE;
    adv      = new_val && (checkbits_i == exp_code);
    is_fail  = new_val && (checkbits_i == FAIL_CODE);
    is_ooo   = new_val && (rel_code > CHECK_W'(stage_q)) && (rel_code < CHECK_W'(NUM_STAGES));
    stage_d  = stage_q + 4'd1;
    last     = (({1'b0, stage_q} + 5'd1) == LAST_STAGE);
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
    tmo      = (tmr_q == TMO_LAST) && !adv;
`else
    tmo      = (cycles_q == TMO_LAST);
`endif
  end

  // Stability filter; runs in every state, cleared by reset and by start_i.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || start_i) begin
      cand_q    <= '0;
      run_q     <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      cand_q <= checkbits_i;
      run_q  <= run_d;
      if (hit) begin
        acc_q     <= checkbits_i;
        acc_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      cycles_q  <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 2'd0;
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else if (start_i) begin
      state_q   <= S_ARMED;
      stage_q   <= '0;
      cycles_q  <= '0;
      busy_q    <= 1'b1;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 2'd0;
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else if (state_q == S_ARMED) begin
      // The terminal edge still counts, so cycles_o equals the edges spent armed.
      cycles_q <= cycles_q + CNT_W'(1);
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
      tmr_q    <= adv ? '0 : tmr_q + CNT_W'(1);
`endif
      if (adv) stage_q <= stage_d;
      if (adv && last) begin
        state_q <= S_PASS;
        busy_q  <= 1'b0;
        pass_q  <= 1'b1;
      end else if (is_fail) begin
        state_q <= S_FAIL;
        busy_q  <= 1'b0;
        fail_q  <= 1'b1;
        err_q   <= 2'd1;
      end else if (is_ooo) begin
        state_q <= S_FAIL;
        busy_q  <= 1'b0;
        fail_q  <= 1'b1;
        err_q   <= 2'd2;
      end else if (tmo) begin
        state_q   <= S_TIMEOUT;
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
        err_q     <= 2'd3;
      end
    end
  end

  assign busy_o     = busy_q;
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign timeout_o  = timeout_q;
  assign err_code_o = err_q;
  assign stage_o    = stage_q;
  assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// tb/tb_dv_checkpoint_monitor.sv - directed vector bench for dv_checkpoint_monitor

module tb_dv_checkpoint_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cb;

  always #5 clk = ~clk;

  logic        a_busy, a_pass, a_fail, a_tmo;
  logic [1:0]  a_err;
  logic [3:0]  a_stage;
  logic [31:0] a_cyc;
  logic        b_busy, b_pass, b_fail, b_tmo;
  logic [1:0]  b_err;
  logic [3:0]  b_stage;
  logic [31:0] b_cyc;

  dv_checkpoint_monitor #(.NUM_STAGES(2), .TIMEOUT_CYC(100)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .checkbits_i(cb),
    .busy_o(a_busy), .pass_o(a_pass), .fail_o(a_fail), .timeout_o(a_tmo),
    .err_code_o(a_err), .stage_o(a_stage), .cycles_o(a_cyc)
  );

  dv_checkpoint_monitor #(.NUM_STAGES(4), .TIMEOUT_CYC(100000)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .checkbits_i(cb),
    .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail), .timeout_o(b_tmo),
    .err_code_o(b_err), .stage_o(b_stage), .cycles_o(b_cyc)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] cb;
    logic [3:0]  stg;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  err;
    int          cyc;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sit 1 ns past it for sampling.
  task automatic tick(input logic r, input logic s, input logic [15:0] c);
    rst   = r;
    start = s;
    cb    = c;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic run(input int n, input logic [15:0] c);
    repeat (n) tick(1'b0, 1'b0, c);
  endtask

  task automatic add(input logic r, input logic s, input logic [15:0] c, input logic [3:0] stg,
                     input logic busy, input logic pass, input logic fail, input logic [1:0] err,
                     input int cyc);
    vq.push_back('{r, s, c, stg, busy, pass, fail, err, cyc});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cb    = 16'h0000;

    // rst st  cb       stg busy pass fail err cyc
    add(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 1);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 2);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 3);
    add(0, 0, 16'hAB60, 1, 1, 0, 0, 0, 4);
    add(0, 0, 16'hAB61, 1, 1, 0, 0, 0, 5);
    add(0, 0, 16'hAB61, 1, 1, 0, 0, 0, 6);
    add(0, 0, 16'hAB61, 1, 1, 0, 0, 0, 7);
    add(0, 0, 16'hAB61, 2, 0, 1, 0, 0, 8);
    add(0, 0, 16'hAB61, 2, 0, 1, 0, 0, 8);
    // glitch: 3-cycle AB60 run broken by one 0000 sample
    add(0, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 1);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 2);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 3);
    add(0, 0, 16'h0000, 0, 1, 0, 0, 0, 4);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 5);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 6);
    add(0, 0, 16'hAB60, 0, 1, 0, 0, 0, 7);
    add(0, 0, 16'hAB60, 1, 1, 0, 0, 0, 8);
    add(0, 0, 16'hAB60, 1, 1, 0, 0, 0, 9);
    // firmware failure code after stage 0
    add(0, 0, 16'hAB6F, 1, 1, 0, 0, 0, 10);
    add(0, 0, 16'hAB6F, 1, 1, 0, 0, 0, 11);
    add(0, 0, 16'hAB6F, 1, 1, 0, 0, 0, 12);
    add(0, 0, 16'hAB6F, 1, 0, 0, 1, 1, 13);
    add(0, 0, 16'hAB6F, 1, 0, 0, 1, 1, 13);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].rst, vq[i].st, vq[i].cb);
      chk($sformatf("v%0d_stage", i), 32'(a_stage), 32'(vq[i].stg));
      chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vq[i].busy));
      chk($sformatf("v%0d_pass", i), 32'(a_pass), 32'(vq[i].pass));
      chk($sformatf("v%0d_fail", i), 32'(a_fail), 32'(vq[i].fail));
      chk($sformatf("v%0d_tmo", i), 32'(a_tmo), 32'd0);
      chk($sformatf("v%0d_err", i), 32'(a_err), 32'(vq[i].err));
      chk($sformatf("v%0d_cycles", i), a_cyc, 32'(vq[i].cyc));
    end

    // out-of-order code: AB62 right after stage 0
    tick(0, 1, 16'h0000);
    run(4, 16'hAB60);
    chk("ooo_b_stage0", 32'(b_stage), 32'd1);
    run(4, 16'hAB62);
    chk("ooo_b_fail", 32'(b_fail), 32'd1);
    chk("ooo_b_err", 32'(b_err), 32'd2);
    chk("ooo_b_stage", 32'(b_stage), 32'd1);
    chk("ooo_b_busy", 32'(b_busy), 32'd0);
    chk("ooo_a_ignored_busy", 32'(a_busy), 32'd1);
    chk("ooo_a_ignored_fail", 32'(a_fail), 32'd0);

    // global timeout with no codes
    tick(0, 1, 16'h0000);
    run(99, 16'h0000);
    chk("tmo_pre_busy", 32'(a_busy), 32'd1);
    chk("tmo_pre_flag", 32'(a_tmo), 32'd0);
    chk("tmo_pre_cycles", a_cyc, 32'd99);
    tick(0, 0, 16'h0000);
    chk("tmo_flag", 32'(a_tmo), 32'd1);
    chk("tmo_err", 32'(a_err), 32'd3);
    chk("tmo_busy", 32'(a_busy), 32'd0);
    chk("tmo_cycles", a_cyc, 32'd100);
    tick(0, 0, 16'h0000);
    chk("tmo_cycles_frozen", a_cyc, 32'd100);
    chk("tmo_pass", 32'(a_pass), 32'd0);

    // final stage accepted on the timeout edge wins
    tick(0, 1, 16'h0000);
    run(10, 16'h0000);
    run(86, 16'hAB60);
    run(4, 16'hAB61);
    chk("race_pass", 32'(a_pass), 32'd1);
    chk("race_tmo", 32'(a_tmo), 32'd0);
    chk("race_err", 32'(a_err), 32'd0);
    chk("race_cycles", a_cyc, 32'd100);
    chk("race_stage", 32'(a_stage), 32'd2);

    // stage 0 at cycle 90, stage 1 at cycle 180
    tick(0, 1, 16'h0000);
    run(86, 16'h0000);
    run(4, 16'hAB60);
    chk("win_stage0", 32'(a_stage), 32'd1);
`ifdef DV_CHKMON_STAGE_TIMEOUT_EN
    run(86, 16'hAB60);
    run(4, 16'hAB61);
    chk("win_pass", 32'(a_pass), 32'd1);
    chk("win_tmo", 32'(a_tmo), 32'd0);
    chk("win_cycles", a_cyc, 32'd180);
`else
    run(10, 16'hAB60);
    chk("win_tmo", 32'(a_tmo), 32'd1);
    chk("win_err", 32'(a_err), 32'd3);
    chk("win_stage", 32'(a_stage), 32'd1);
    chk("win_cycles", a_cyc, 32'd100);
`endif

    // reset mid-armed, then restart mid-armed
    tick(0, 1, 16'h0000);
    run(4, 16'hAB60);
    chk("rst_pre_stage", 32'(a_stage), 32'd1);
    tick(1, 0, 16'hAB60);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_stage", 32'(a_stage), 32'd0);
    chk("rst_cycles", a_cyc, 32'd0);
    chk("rst_verdict", {29'd0, a_pass, a_fail, a_tmo}, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    tick(0, 1, 16'h0000);
    run(4, 16'hAB60);
    run(2, 16'hAB61);
    chk("rearm_pre_stage", 32'(a_stage), 32'd1);
    tick(0, 1, 16'hAB61);
    chk("rearm_stage", 32'(a_stage), 32'd0);
    chk("rearm_cycles", a_cyc, 32'd0);
    chk("rearm_busy", 32'(a_busy), 32'd1);
    // filter was cleared, so AB61 is accepted afresh and is now out of order
    run(4, 16'hAB61);
    chk("rearm_ooo_fail", 32'(a_fail), 32'd1);
    chk("rearm_ooo_err", 32'(a_err), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
